inv_sub_bytes_seq: RTL and testbench

INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

---
 rtl/inv_sub_bytes_seq_pkg.sv | 30 +++
 rtl/inv_sub_bytes_seq_sbox.sv | 30 +++
 rtl/inv_sub_bytes_seq.sv | 88 ++++++++
 tb/tb_inv_sub_bytes_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared constants and GF(2^8) helpers for the word-serial AES inverse SubBytes block.
package inv_sub_bytes_seq_pkg;

    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;
    localparam int STATE_W   = 128;
    localparam int NUM_WORDS = 4;

    localparam logic [1:0] LAST_WORD = 2'(NUM_WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [BYTE_W-1:0] byte_t;

    // Multiply in GF(2^8) modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) acc ^= sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_sbox.sv
// Combinational AES inverse S-box: undo the affine transform, then invert in GF(2^8).
module inverse_substitution_box
    import inv_sub_bytes_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] A,
    output logic [BYTE_W-1:0] C
);

    byte_t t;
    byte_t x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;

    always_comb begin
        t    = {A[6:0], A[7]} ^ {A[4:0], A[7:5]} ^ {A[1:0], A[7:2]} ^ 8'h05;
        // Inverse as t^254 via an addition chain; maps 0 to 0 as required.
        x2   = gf_mul(t, t);
        x3   = gf_mul(x2, t);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, t);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, t);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, t);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, t);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, t);
        C    = gf_mul(x127, x127);
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Word-serial inverse SubBytes with folded round key: one 32-bit word per cycle, valid/ready on both sides.
module inv_sub_bytes_seq
    import inv_sub_bytes_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] IN_DATA,
    input  logic [STATE_W-1:0] IN_KEY,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] ISB_DATA,
    output logic               busy
);

    logic [1:0]         state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [STATE_W-1:0] hold_q, hold_d;
    logic [WORD_W-1:0]  kf_q, kf_d;
    logic [STATE_W-1:0] res_q, res_d;
    logic [WORD_W-1:0]  key_fold;
    logic [WORD_W-1:0]  word_in;
    logic [WORD_W-1:0]  sub_word;
    logic [WORD_W-1:0]  word_out;

    assign key_fold = IN_KEY[127:96] ^ IN_KEY[95:64] ^ IN_KEY[63:32] ^ IN_KEY[31:0];

    // Word 0 sits in the top bits, so the bit offset is (3 - cnt) * 32.
    assign word_in  = hold_q[{~cnt_q, 5'b0} +: WORD_W];
    assign word_out = sub_word ^ kf_q;

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_sbox
        inverse_substitution_box u_isb (
            .A (word_in [WORD_W-1-BYTE_W*g -: BYTE_W]),
            .C (sub_word[WORD_W-1-BYTE_W*g -: BYTE_W])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        kf_d    = kf_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    hold_d  = IN_DATA;
                    kf_d    = key_fold;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[{~cnt_q, 5'b0} +: WORD_W] = word_out;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_WORD) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            kf_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            kf_q    <= kf_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign ISB_DATA  = res_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: fixed vectors, handshake/reset sequences and random round trips.
module tb_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] IN_DATA = '0;
    logic [127:0] IN_KEY = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ISB_DATA;
    logic         busy;

    always #5 clk = ~clk;

    inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .IN_DATA   (IN_DATA),
        .IN_KEY    (IN_KEY),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ISB_DATA  (ISB_DATA),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] inv_sbox [256];

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [31:0] fold(input logic [127:0] k);
        return k[127:96] ^ k[95:64] ^ k[63:32] ^ k[31:0];
    endfunction

    function automatic logic [127:0] ref_isb(input logic [127:0] d, input logic [127:0] k);
        logic [31:0]  kf;
        logic [127:0] r;
        kf = fold(k);
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv_sbox[d[127-8*i -: 8]] ^ kf[31-8*(i%4) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] fwd(input logic [127:0] d, input logic [127:0] k);
        logic [31:0]  kf;
        logic [127:0] r;
        kf = fold(k);
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = sbox[d[127-8*i -: 8] ^ kf[31-8*(i%4) -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start(input logic [127:0] d, input logic [127:0] k);
        check("in_ready_idle", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        IN_DATA  = d;
        IN_KEY   = k;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit scramble, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("busy_run", 128'(busy), 128'd1);
            if (scramble) begin
                IN_DATA   = rnd128();
                IN_KEY    = rnd128();
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("done_reached", 128'(out_valid), 128'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("ov_drop", 128'(out_valid), 128'd0);
        check("in_ready_back", 128'(in_ready), 128'd1);
    endtask

    task automatic run_block(input logic [127:0] d, input logic [127:0] k, input bit scramble,
                             output logic [127:0] res);
        int lat;
        start(d, k);
        wait_done(scramble, lat);
        check("latency", 128'(lat), 128'd4);
        res = ISB_DATA;
        handshake();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] res, held, d, k, d2, k2;
        int lat;

        for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);

        vecs[0] = '{ {16{8'h63}}, 128'h0, 128'h0 };
        vecs[1] = '{ {16{8'h7c}}, 128'h01000000_00000000_00000000_00000000,
                     128'h00010101_00010101_00010101_00010101 };
        vecs[2] = '{ 128'h0, 128'h0, {16{8'h52}} };
        vecs[3] = '{ {16{8'h63}}, {128{1'b1}}, 128'h0 };
        vecs[4] = '{ {16{8'h63}}, 128'h10203040_00000000_00000000_00000000, {4{32'h10203040}} };
        vecs[5] = '{ 128'h63636363_7c7c7c7c_00000000_52525252,
                     128'h00000000_000f0000_00000000_00000000,
                     128'h000f0000_010e0101_525d5252_48474848 };

        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_isb", ISB_DATA, 128'h0);
        rst_n = 1'b1;
        check("rst_in_ready", 128'(in_ready), 128'd1);

        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].data, vecs[i].key, 1'b0, res);
            check($sformatf("vec%0d", i), res, vecs[i].exp);
        end

        // Consumer stalls 10 cycles while a second request waits.
        d = rnd128(); k = rnd128();
        start(d, k);
        wait_done(1'b0, lat);
        check("hold_latency", 128'(lat), 128'd4);
        held = ISB_DATA;
        check("hold_first", held, ref_isb(d, k));
        d2 = rnd128(); k2 = rnd128();
        in_valid = 1'b1; IN_DATA = d2; IN_KEY = k2;
        repeat (10) begin
            @(negedge clk);
            check("hold_ov", 128'(out_valid), 128'd1);
            check("hold_isb", ISB_DATA, held);
            check("hold_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_ov_drop", 128'(out_valid), 128'd0);
        check("hold_idle", 128'(in_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("second_busy", 128'(busy), 128'd1);
        check("second_in_ready", 128'(in_ready), 128'd0);
        wait_done(1'b0, lat);
        check("second_latency", 128'(lat), 128'd4);
        check("second_result", ISB_DATA, ref_isb(d2, k2));
        handshake();

        // Inputs scrambled every RUN cycle.
        d = rnd128(); k = rnd128();
        run_block(d, k, 1'b1, res);
        check("scramble_result", res, ref_isb(d, k));

        // Asynchronous reset while cnt=2.
        d = rnd128(); k = rnd128();
        start(d, k);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ov", 128'(out_valid), 128'd0);
        check("midrst_isb", ISB_DATA, 128'h0);
        check("midrst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d = rnd128(); k = rnd128();
        run_block(d, k, 1'b0, res);
        check("after_rst_result", res, ref_isb(d, k));

        // Round trip through the forward model.
        for (int i = 0; i < 1000; i++) begin
            d = rnd128(); k = rnd128();
            run_block(fwd(d, k), k, 1'(i % 2), res);
            check("roundtrip", res, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
